spi_ram_ctrl: RTL and testbench

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_pkg.sv | 18 +
 rtl/spi_ram_array.sv | 21 ++
 rtl/spi_ram_ctrl.sv | 84 ++++++++
 tb/tb_spi_ram_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes, sequence-state encoding and default geometry for spi_ram_ctrl
package spi_ram_pkg;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;
  // bit 0 = write address loaded, bit 1 = read address loaded
  typedef enum logic [1:0] {
    ST_NONE  = 2'b00,
    ST_WR_OK = 2'b01,
    ST_RD_OK = 2'b10,
    ST_BOTH  = 2'b11
  } seq_state_e;
endpackage

// File: rtl/spi_ram_array.sv
// spi_ram_array: byte-wide storage, one write port and one registered read port, no reset
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request; rdata_o holds the
// last read byte until the next read request.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder between an SPI slave and a byte RAM
// Ports: clk; rst_n async active-low; din[9:8] opcode, din[7:0] payload, qualified by rx_valid;
// dout read byte qualified by a one-cycle tx_valid; cmd_err pulses on an out-of-sequence command.
// Build option: define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each
// accepted WR_DATA/RD_DATA.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);
  if (MEM_DEPTH != 2 ** ADDR_SIZE) begin : g_depth_chk
    $error("spi_ram_ctrl: MEM_DEPTH must equal 2**ADDR_SIZE");
  end
  seq_state_e state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic live_q, rd_seen_q, tx_valid_q, cmd_err_q;
  logic accept, wr_ok, rd_ok, do_wr, do_rd, bad_cmd;
  logic [7:0] rdata;
  opcode_e op;
  // live_q stays low for the first edge after reset release, so a command there is ignored
  assign accept  = rx_valid && live_q;
  assign op      = opcode_e'(din[9:8]);
  assign wr_ok   = state_q[0];
  assign rd_ok   = state_q[1];
  assign do_wr   = accept && op == OP_WR_DATA && wr_ok;
  assign do_rd   = accept && op == OP_RD_DATA && rd_ok;
  assign bad_cmd = accept && ((op == OP_WR_DATA && !wr_ok) || (op == OP_RD_DATA && !rd_ok));
  always_comb begin
    state_d = state_q;
    if (accept && op == OP_WR_ADDR) state_d = rd_ok ? ST_BOTH : ST_WR_OK;
    if (accept && op == OP_RD_ADDR) state_d = wr_ok ? ST_BOTH : ST_RD_OK;
  end
`ifdef SPI_RAM_AUTOINC_EN
  assign wr_addr_d = (accept && op == OP_WR_ADDR) ? din[ADDR_SIZE-1:0] :
                     do_wr ? wr_addr_q + ADDR_SIZE'(1) : wr_addr_q;
  assign rd_addr_d = (accept && op == OP_RD_ADDR) ? din[ADDR_SIZE-1:0] :
                     do_rd ? rd_addr_q + ADDR_SIZE'(1) : rd_addr_q;
`else
  assign wr_addr_d = (accept && op == OP_WR_ADDR) ? din[ADDR_SIZE-1:0] : wr_addr_q;
  assign rd_addr_d = (accept && op == OP_RD_ADDR) ? din[ADDR_SIZE-1:0] : rd_addr_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NONE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      live_q     <= 1'b0;
      rd_seen_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      live_q     <= 1'b1;
      rd_seen_q  <= rd_seen_q || do_rd;
      tx_valid_q <= do_rd;
      cmd_err_q  <= bad_cmd;
    end
  end
  // The RAM read register is not reset; mask it to zero until the first read after reset.
  // A write followed next cycle by a read of the same address sees the new byte naturally.
  spi_ram_array #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_array (
    .clk    (clk),
    .we_i   (do_wr),
    .waddr_i(wr_addr_q),
    .wdata_i(din[7:0]),
    .re_i   (do_rd),
    .raddr_i(rd_addr_q),
    .rdata_o(rdata)
  );
  assign dout     = rd_seen_q ? rdata : 8'h00;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: scoreboard bench for spi_ram_ctrl with directed command sequences
module tb_spi_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic tx_valid, cmd_err;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  spi_ram_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid),
    .cmd_err (cmd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask
  task automatic send(input logic [9:0] w);
    @(negedge clk);
    din = w;
    rx_valid = 1'b1;
  endtask
  task automatic exp_rd(input logic [7:0] d);
    q.push_back('{1'b0, d, cyc + 1});
  endtask
  task automatic exp_err();
    q.push_back('{1'b1, 8'h00, cyc + 1});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      din = 10'($urandom);
    end
  endtask
  // monitor: every output event must match the head of the expected queue, including its cycle
  always @(negedge clk) begin
    if (tx_valid || cmd_err) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event tx_valid=%b cmd_err=%b dout=%02h cyc=%0d",
                 tx_valid, cmd_err, dout, cyc);
      end else begin
        e = q.pop_front();
        total++;
        if (cmd_err == e.err && tx_valid == !e.err && (e.err || dout == e.data) && cyc == e.at)
          passed++;
        else
          $display("FAIL event actual tx_valid=%b cmd_err=%b dout=%02h cyc=%0d expected err=%b data=%02h cyc=%0d",
                   tx_valid, cmd_err, dout, cyc, e.err, e.data, e.at);
      end
    end
  end
  initial begin
    rx_valid = 1'b1;
    din = 10'h3FF;
    repeat (3) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_cmd_err", 32'(cmd_err), 32'h0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    // basic write then read back
    send(10'h055);
    send(10'h1A5);
    send(10'h255);
    send(10'h300); exp_rd(8'hA5);
    idle(2);
    // four consecutive commands
    send(10'h010);
    send(10'h13C);
    send(10'h210);
    send(10'h300); exp_rd(8'h3C);
    idle(2);
    // address FF boundary, back-to-back reads
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
`ifdef SPI_RAM_AUTOINC_EN
    send(10'h300); exp_rd(8'h11);
`else
    send(10'h300); exp_rd(8'h22);
`endif
    send(10'h300); exp_rd(8'h22);
    // known byte at address 0 for the dropped-write check later
    send(10'h000);
    send(10'h15A);
    // idle cycles with random din must leave everything alone
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("idle_dout", 32'(dout), 32'h22);
    end
    // reset mid-sequence with rx_valid held high, command present at release
    send(10'h020);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_dout", 32'(dout), 32'h00);
    chk("midreset_tx_valid", 32'(tx_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h1FF); exp_err();
    send(10'h3FF); exp_err();
    idle(1);
    chk("err_dout_held", 32'(dout), 32'h00);
    chk("err_tx_valid", 32'(tx_valid), 32'h0);
    send(10'h200);
    send(10'h300); exp_rd(8'h5A);
    idle(2);
    // write then read of the same address on the next cycle
    send(10'h000);
    send(10'h200);
    send(10'h1C3);
    send(10'h300); exp_rd(8'hC3);
    idle(3);
    chk("dout_holds", 32'(dout), 32'hC3);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
